// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-FIFO entry layout and SW0/SW1 frame-format decode.
package uart_pkg;

    localparam int ENTRY_W     = 10;
    localparam int BYTE_LSB    = 0;
    localparam int BYTE_W      = 8;
    localparam int PAR_ERR_BIT = 8;
    localparam int FRM_ERR_BIT = 9;

    localparam logic SW0_NO_PARITY   = 1'b0;
    localparam logic SW0_EVEN_PARITY = 1'b1;
    localparam logic SW1_DATA7       = 1'b0;
    localparam logic SW1_DATA8       = 1'b1;

    // Packed so that frm_err lands on FRM_ERR_BIT and par_err on PAR_ERR_BIT.
    typedef struct packed {
        logic       frm_err;
        logic       par_err;
        logic [7:0] data;
    } entry_t;

    // Even parity: data bits plus the parity bit that follows them must hold an even count of ones.
    function automatic logic calc_par_err(input logic [8:0] frame, input logic sw0, input logic sw1);
        logic err;
        err = 1'b0;
        if (sw0 == SW0_EVEN_PARITY) begin
            if (sw1 == SW1_DATA8) err = (^frame[7:0]) ^ frame[8];
            else                  err = (^frame[6:0]) ^ frame[7];
        end
        return err;
    endfunction

    function automatic logic [7:0] strip_byte(input logic [8:0] frame, input logic sw1);
        return (sw1 == SW1_DATA8) ? frame[7:0] : {1'b0, frame[6:0]};
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic show-ahead synchronous FIFO; accepts a push while full if a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          push_drop
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_eff, pop_eff;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign pop_eff   = pop && !empty;
    assign push_eff  = push && (!full || pop_eff);
    assign push_drop = push && !push_eff;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push_eff} - {{AW{1'b0}}, pop_eff};
        if (push_eff) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_eff) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rx_frame_buffer.sv
// Receive frame buffer: edge-detects frame/error events, strips framing, checks parity, queues entries.
module rx_frame_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [8:0]    frame_in,
    input  logic          data_valid,
    input  logic          frame_err,
    input  logic          SW0,
    input  logic          SW1,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_par_err,
    output logic          rd_frm_err,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf
);

    logic   dv_q, dv_d;
    logic   fe_q, fe_d;
    logic   ovf_q, ovf_d;
    logic   push_ok, push_fe, push;
    logic   push_drop;
    entry_t wentry, head;

    assign push_ok = data_valid & ~dv_q;
    assign push_fe = frame_err & ~fe_q;
    assign push    = push_ok | push_fe;

    // A framing error wins over a simultaneous frame-complete edge.
    always_comb begin
        wentry = '0;
        if (push_fe) begin
            wentry.frm_err = 1'b1;
        end else begin
            wentry.data    = strip_byte(frame_in, SW1);
            wentry.par_err = calc_par_err(frame_in, SW0, SW1);
        end
    end

    uart_sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(ENTRY_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wdata     (wentry),
        .pop       (rd_en),
        .rdata     (head),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .push_drop (push_drop)
    );

    assign rd_data    = empty ? 8'h00 : head.data;
    assign rd_par_err = empty ? 1'b0  : head.par_err;
    assign rd_frm_err = empty ? 1'b0  : head.frm_err;
    assign overflow   = ovf_q;

    always_comb begin
        dv_d  = data_valid;
        fe_d  = frame_err;
        ovf_d = ovf_q;
        if (clr_ovf)   ovf_d = 1'b0;
        if (push_drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_q  <= 1'b0;
            fe_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            dv_q  <= dv_d;
            fe_q  <= fe_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Bench for rx_frame_buffer: decode vector table, multi-cycle corner sequences, randomized run vs. queue model.
module tb_rx_frame_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [8:0]    frame_in;
    logic          data_valid, frame_err, SW0, SW1, rd_en, clr_ovf;
    logic [7:0]    rd_data;
    logic          rd_par_err, rd_frm_err, empty, full, overflow;
    logic [AW:0]   count;

    int checks   = 0;
    int failures = 0;

    rx_frame_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .frame_in(frame_in), .data_valid(data_valid),
        .frame_err(frame_err), .SW0(SW0), .SW1(SW1), .rd_en(rd_en),
        .rd_data(rd_data), .rd_par_err(rd_par_err), .rd_frm_err(rd_frm_err),
        .empty(empty), .full(full), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: queue of {frm_err, par_err, byte} entries.
    logic [9:0] exp_q[$];
    logic       m_prev_dv, m_prev_fe, m_ovf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic       ev_frame, ev_err, do_pop, have_push;
        logic [9:0] e;
        logic [7:0] b;
        int         ones;
        if (rst) begin
            exp_q.delete();
            m_prev_dv = 1'b0;
            m_prev_fe = 1'b0;
            m_ovf     = 1'b0;
            return;
        end
        ev_frame  = data_valid && !m_prev_dv;
        ev_err    = frame_err && !m_prev_fe;
        m_prev_dv = data_valid;
        m_prev_fe = frame_err;
        have_push = ev_frame || ev_err;
        e = '0;
        if (ev_err) begin
            e = {1'b1, 1'b0, 8'h00};
        end else if (ev_frame) begin
            if (SW1) begin
                b    = frame_in[7:0];
                ones = $countones(frame_in[7:0]) + int'(frame_in[8]);
            end else begin
                b    = {1'b0, frame_in[6:0]};
                ones = $countones(frame_in[6:0]) + int'(frame_in[7]);
            end
            e = {1'b0, (SW0 && (ones % 2 == 1)), b};
        end
        do_pop = rd_en && (exp_q.size() > 0);
        if (have_push && exp_q.size() == DEPTH && !do_pop) begin
            m_ovf = 1'b1;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (have_push) exp_q.push_back(e);
            if (clr_ovf) m_ovf = 1'b0;
        end
    endtask

    task automatic check_model();
        logic [9:0] h;
        h = (exp_q.size() > 0) ? exp_q[0] : 10'h000;
        chk("m_rd_data",    int'(rd_data),    int'(h[7:0]));
        chk("m_rd_par_err", int'(rd_par_err), int'(h[8]));
        chk("m_rd_frm_err", int'(rd_frm_err), int'(h[9]));
        chk("m_empty",      int'(empty),      int'(exp_q.size() == 0));
        chk("m_full",       int'(full),       int'(exp_q.size() == DEPTH));
        chk("m_count",      int'(count),      exp_q.size());
        chk("m_overflow",   int'(overflow),   int'(m_ovf));
    endtask

    // Inputs are driven at the negedge; model and DUT both advance on the following posedge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic       sw1;
        logic       sw0;
        logic [8:0] frame;
        logic       fe;
        logic [7:0] exp_byte;
        logic       exp_par;
        logic       exp_frm;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 9'h0A5, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 9'h1A5, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 9'h0A5, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 9'h0D5, 1'b0, 8'h55, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 9'h055, 1'b0, 8'h55, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 9'h1FF, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 9'h0A5, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 9'h0FF, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 9'h0AA, 1'b0, 8'h2A, 1'b0, 1'b0};

        rst = 1'b1; frame_in = '0; data_valid = 0; frame_err = 0;
        SW0 = 0; SW1 = 0; rd_en = 0; clr_ovf = 0;
        m_prev_dv = 0; m_prev_fe = 0; m_ovf = 0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_empty", int'(empty), 1);
        chk("reset_full", int'(full), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        cycle();

        // Single-frame decode table: push, check head, pop.
        for (int i = 0; i < 9; i++) begin
            SW1 = vecs[i].sw1; SW0 = vecs[i].sw0; frame_in = vecs[i].frame;
            if (vecs[i].fe) frame_err = 1'b1; else data_valid = 1'b1;
            cycle();
            data_valid = 0; frame_err = 0;
            chk($sformatf("vec%0d_count", i), int'(count), 1);
            chk($sformatf("vec%0d_data", i), int'(rd_data), int'(vecs[i].exp_byte));
            chk($sformatf("vec%0d_par", i), int'(rd_par_err), int'(vecs[i].exp_par));
            chk($sformatf("vec%0d_frm", i), int'(rd_frm_err), int'(vecs[i].exp_frm));
            rd_en = 1'b1;
            cycle();
            rd_en = 1'b0;
            chk($sformatf("vec%0d_popped", i), int'(empty), 1);
        end

        // frame_err held high for 20 cycles yields one entry.
        frame_err = 1'b1;
        repeat (20) cycle();
        frame_err = 1'b0;
        cycle();
        chk("fe_hold_count", int'(count), 1);
        chk("fe_hold_frm", int'(rd_frm_err), 1);
        chk("fe_hold_data", int'(rd_data), 0);
        rd_en = 1'b1; cycle(); rd_en = 1'b0;

        // Nine pushes into an 8-deep FIFO, then push+pop at full, then clear overflow.
        SW1 = 1'b1; SW0 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            frame_in = 9'(i + 1);
            data_valid = 1'b1; cycle();
            data_valid = 1'b0; cycle();
        end
        chk("ovf_count", int'(count), 8);
        chk("ovf_full", int'(full), 1);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_head", int'(rd_data), 1);
        frame_in = 9'h0AA; data_valid = 1'b1; rd_en = 1'b1;
        cycle();
        data_valid = 1'b0; rd_en = 1'b0;
        chk("pushpop_count", int'(count), 8);
        chk("pushpop_head", int'(rd_data), 2);
        chk("pushpop_ovf", int'(overflow), 1);
        clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
        chk("clr_ovf", int'(overflow), 0);
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), int'(rd_data), (i < 7) ? i + 2 : 'hAA);
            cycle();
        end
        rd_en = 1'b0;
        chk("drain_empty", int'(empty), 1);

        // Asynchronous reset with five entries held.
        for (int i = 0; i < 5; i++) begin
            frame_in = 9'(8'h30 + i);
            data_valid = 1'b1; cycle();
            data_valid = 1'b0; cycle();
        end
        chk("pre_rst_count", int'(count), 5);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_data", int'(rd_data), 0);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        rd_en = 1'b1; cycle(); rd_en = 1'b0;
        chk("pop_empty_count", int'(count), 0);
        chk("pop_empty_empty", int'(empty), 1);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            int rd_pct;
            rd_pct = (n < 1000) ? 15 : (n < 2000) ? 60 : 35;
            data_valid = ($urandom_range(0, 99) < 45);
            frame_err  = ($urandom_range(0, 99) < 5);
            frame_in   = 9'($urandom_range(0, 511));
            SW0        = 1'($urandom_range(0, 1));
            SW1        = 1'($urandom_range(0, 1));
            rd_en      = ($urandom_range(0, 99) < rd_pct);
            clr_ovf    = ($urandom_range(0, 99) < 3);
            rst        = (n == 1500);
            cycle();
        end
        rst = 1'b0; data_valid = 0; frame_err = 0; rd_en = 0; clr_ovf = 0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
